// File: rtl/lane_seq.sv
// Time-multiplexing sequencer: runs one 4-element vector op through a single
// combinational lane over four cycles and returns the assembled result vector.
module lane_seq #(
    parameter int LANES = 4,
    parameter int W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_ctrl,
    input  logic [LANES*W-1:0]   in_vec,
    input  logic [1:0]           in_idx,
    input  logic [W-1:0]         in_srcb,
    output logic [2:0]           lane_ctrl,
    output logic [1:0]           lane_id,
    output logic [W-1:0]         lane_v,
    output logic [1:0]           lane_idx,
    output logic [W-1:0]         lane_srcb,
    input  logic [W-1:0]         lane_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_vec,
    output logic                 busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         cnt;
    logic [2:0]         ctrl_q;
    logic [LANES*W-1:0] vec_q;
    logic [1:0]         idx_q;
    logic [W-1:0]       srcb_q;
    logic [LANES*W-1:0] res_q;
    logic               accept;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    // Gate the result so a stale vector from a discarded op is never visible.
    assign out_vec   = (state == DONE) ? res_q : '0;

    always_comb begin
        lane_ctrl = '0;
        lane_id   = '0;
        lane_v    = '0;
        lane_idx  = '0;
        lane_srcb = '0;
        if (state == RUN) begin
            lane_ctrl = ctrl_q;
            lane_id   = cnt;
            lane_v    = vec_q[int'(cnt)*W +: W];
            lane_idx  = idx_q;
            lane_srcb = srcb_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ctrl_q <= '0;
            vec_q  <= '0;
            idx_q  <= '0;
            srcb_q <= '0;
            res_q  <= '0;
        end else if (accept) begin
            // Accept from DONE delivers the current result on this same edge.
            ctrl_q <= in_ctrl;
            vec_q  <= in_vec;
            idx_q  <= in_idx;
            srcb_q <= in_srcb;
            cnt    <= '0;
            state  <= RUN;
        end else begin
            case (state)
                RUN: begin
                    res_q[int'(cnt)*W +: W] <= lane_res;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                IDLE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_seq.sv
// Scoreboard bench for lane_seq using a stub lane: res = v + lane_id.
module tb_lane_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_ctrl;
    logic [63:0] in_vec;
    logic [1:0]  in_idx;
    logic [15:0] in_srcb;
    logic [2:0]  lane_ctrl;
    logic [1:0]  lane_id;
    logic [15:0] lane_v;
    logic [1:0]  lane_idx;
    logic [15:0] lane_srcb;
    logic [15:0] lane_res;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_vec;
    logic        busy;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    logic [63:0] sb[$];
    int unsigned hs_cyc[$];

    lane_seq #(.LANES(4), .W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_vec(in_vec), .in_idx(in_idx), .in_srcb(in_srcb),
        .lane_ctrl(lane_ctrl), .lane_id(lane_id), .lane_v(lane_v),
        .lane_idx(lane_idx), .lane_srcb(lane_srcb), .lane_res(lane_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .busy(busy)
    );

    assign lane_res = lane_v + {14'b0, lane_id};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = v[i*16 +: 16] + 16'(i);
        return r;
    endfunction

    // Handshakes are judged at the negedge; inputs only move at posedge+1.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) check_eq("unexpected_out", 64'd1, 64'd0);
                else check_eq("out_vec", out_vec, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(model(in_vec));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [2:0] c, input logic [63:0] v,
                        input logic [1:0] ix, input logic [15:0] s);
        logic ok = 1'b0;
        in_valid = 1'b1; in_ctrl = c; in_vec = v; in_idx = ix; in_srcb = s;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        check_eq("accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        check_eq("drain", 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [2:0] c, input logic [63:0] v,
                          input logic [1:0] ix, input logic [15:0] s);
        out_ready = 1'b1;
        send(c, v, ix, s);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("lane_id", 64'(lane_id), 64'(k));
            check_eq("lane_v", 64'(lane_v), 64'(v[k*16 +: 16]));
            check_eq("lane_ctrl", 64'(lane_ctrl), 64'(c));
            check_eq("lane_idx", 64'(lane_idx), 64'(ix));
            check_eq("lane_srcb", 64'(lane_srcb), 64'(s));
            check_eq("busy_run", 64'(busy), 64'd1);
        end
        @(negedge clk);
        check_eq("out_valid_done", 64'(out_valid), 64'd1);
        @(negedge clk);
        check_eq("out_valid_idle", 64'(out_valid), 64'd0);
        check_eq("busy_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic ok;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_vec = '0; in_idx = '0; in_srcb = '0;

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_vec", out_vec, 64'd0);
        check_eq("rst_lane_id", 64'(lane_id), 64'd0);
        check_eq("rst_lane_v", 64'(lane_v), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // single op and passthrough
        run_op(3'b000, 64'h0004_0003_0002_0001, 2'd0, 16'h0000);
        check_eq("sb_empty_single", 64'(sb.size()), 64'd0);
        run_op(3'b100, 64'hDEAD_BEEF_1234_FFFF, 2'd2, 16'h5A5A);
        for (int n = 0; n < 3; n++)
            run_op(3'($urandom), {$urandom, $urandom}, 2'($urandom), 16'($urandom));

        // backpressure, then simultaneous deliver + accept
        out_ready = 1'b0;
        send(3'b001, 64'h1111_2222_3333_4444, 2'd1, 16'h0042);
        repeat (4) @(negedge clk);
        @(negedge clk);
        check_eq("bp_valid_rise", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_vec = 64'h0100_0200_0300_0400;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_vec", out_vec, model(64'h1111_2222_3333_4444));
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // back-to-back
        hs_cyc.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; in_vec = 64'h0; in_ctrl = 3'b010;
        @(negedge clk);
        check_eq("b2b_first_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_vec = 64'h0010_0010_0010_0010;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        check_eq("b2b_second_accept", 64'(ok), 64'd1);
        check_eq("b2b_overlap", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        check_eq("b2b_count", 64'(hs_cyc.size()), 64'd2);
        check_eq("b2b_gap", (hs_cyc.size() >= 2) ? 64'(hs_cyc[1] - hs_cyc[0]) : 64'd0, 64'd5);
        check_eq("b2b_model", model(64'h0010_0010_0010_0010), 64'h0013_0012_0011_0010);

        // reset mid-RUN
        send(3'b011, 64'hAAAA_BBBB_CCCC_DDDD, 2'd3, 16'h7777);
        repeat (2) @(negedge clk);
        @(negedge clk);
        check_eq("mid_cnt2", 64'(lane_id), 64'd2);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_eq("mid_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_busy", 64'(busy), 64'd0);
        check_eq("mid_lane", {lane_v, lane_srcb, 25'd0, lane_ctrl, lane_id, lane_idx}, 64'd0);
        check_eq("mid_out_vec", out_vec, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hs_cyc.delete();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("post_rst_busy", 64'(busy), 64'd0);
            check_eq("post_rst_valid", 64'(out_valid), 64'd0);
        end
        check_eq("post_rst_no_out", 64'(hs_cyc.size()), 64'd0);
        check_eq("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_seq.md
# lane_seq

Time-multiplexing sequencer that runs one 4-element vector operation through a single physical `lane` instance over four consecutive cycles. It accepts a decoded vector operation (control, 64-bit vector operand, index, scalar/immediate) over a valid/ready handshake. Each cycle it presents one 16-bit element with its `LaneId` to the lane and captures the lane's combinational `Res`. It then returns the assembled 64-bit result vector downstream, toward register writeback, over a second valid/ready handshake.

## Interface
- `LANES`, 4: elements per vector; fixed at 4, since lane IDs are 2 bits.
- `W`, 16: element width in bits.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  sequencer can accept an operation.
- `in_ctrl`  in  3  lane control; bit 0 = size, bits 2:1 = op.
- `in_vec`  in  64  vector operand; element i = `in_vec[16i+15:16i]`.
- `in_idx`  in  2  element index for single-element ops.
- `in_srcb`  in  16  scalar register or immediate.
- `lane_ctrl`  out  3  to lane `LaneControl`.
- `lane_id`  out  2  to lane `LaneId`.
- `lane_v`  out  16  to lane `V`.
- `lane_idx`  out  2  to lane `Idx`.
- `lane_srcb`  out  16  to lane `SrcB`.
- `lane_res`  in  16  from lane `Res`; combinational, same cycle.
- `out_valid`  out  1  result vector available.
- `out_ready`  in  1  downstream accepts the result.
- `out_vec`  out  64  result; element i from lane_id i.
- `busy`  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: waiting for an operation.
  - RUN: counter `cnt` steps 0..3.
  - DONE: result held.
- Accept condition: `in_ready = (IDLE) | (DONE & out_ready)`. An operation is accepted on `in_valid & in_ready`.
- On accept:
  - Latch `in_ctrl`, `in_vec`, `in_idx`, `in_srcb`.
  - Set `cnt` = 0.
  - Next state is RUN. This holds from both IDLE and DONE.
- RUN drives the lane:
  - `lane_id = cnt`.
  - `lane_v` = latched element `cnt`.
  - `lane_ctrl`, `lane_idx`, `lane_srcb` = latched values, held constant for all 4 cycles.
- RUN capture, each edge:
  - `lane_res` is written into result slot `cnt`.
  - `cnt` increments.
  - At `cnt == 3` the final element is captured and the next state is DONE. `cnt` wraps to 0.
- DONE:
  - `out_valid` = 1.
  - `out_vec` is stable until the handshake.
  - On `out_valid & out_ready` with no new accept, next state is IDLE.
- Outside RUN, all `lane_*` outputs are 0.
- Index semantics: the sequencer never interprets `in_idx` or the op. It passes them through unchanged, and every element is always visited.
- `in_valid` while in RUN, or in DONE with `out_ready` = 0, is ignored. Upstream must hold its operation.
- Result slots are overwritten only during RUN. `out_vec` in DONE is exactly the 4 captured words.
- `busy` = (RUN | DONE).

## Timing
- Reset values, asynchronous on `rst_n` = 0:
  - State = IDLE, `cnt` = 0.
  - `out_valid` = 0, `out_vec` = 0, `busy` = 0.
  - All `lane_*` = 0.
  - `in_ready` = 1 after reset releases.
- Reset mid-RUN or in DONE: the operation is discarded and the outputs return to their reset values immediately. No partial result is ever presented.
- Latency: accept on edge E0, elements captured on E1..E4. `out_valid` rises after E4, 4 cycles after accept.
- Throughput:
  - With `out_ready` held high: one operation per 5 cycles, since the DONE→RUN transition overlaps the output handshake.
  - With `out_ready` low, DONE holds indefinitely.
- Simultaneous output handshake and new accept in DONE: the result is delivered and the new operation begins on the same edge. `out_vec` changes only after that edge.
- The lane is combinational. Its path `lane_v` → `lane_res` must close within one cycle.

## Test plan
Benches use a stub lane with `lane_res = lane_v + {14'b0, lane_id}` unless a real `lane` is stated.

- Reset check: assert `rst_n` = 0 for 2 cycles → `out_valid` = 0, `out_vec` = 0, `lane_id` = 0, `busy` = 0. After release, `in_ready` = 1.
- Single operation: `in_vec` = 0x0004_0003_0002_0001, accepted at E0, `out_ready` = 1 → `lane_id` = 0,1,2,3 on successive cycles. `out_valid` rises after E4 with `out_vec` = 0x0007_0005_0003_0001. Next state is IDLE.
- Backpressure: `out_ready` = 0 for 10 cycles after DONE → `out_valid` and `out_vec` held stable. A new `in_valid` during this time is not accepted (`in_ready` = 0).
- Back-to-back: two operations (0x0000…, then 0x0010_0010_0010_0010), `in_valid` and `out_ready` held high → second accept on the same edge as the first output handshake. Second result is 0x0013_0012_0011_0010. Exactly 5 cycles between `out_valid` pulses.
- Reset mid-RUN: `rst_n` low at `cnt` = 2 → immediately `out_valid` = 0, `busy` = 0, `lane_*` = 0. No result is emitted after release.
- Passthrough: with the real `lane`, `in_ctrl` = 3'b100, `in_idx` = 2 → `lane_ctrl` = 3'b100 and `lane_idx` = 2 on all 4 RUN cycles. `out_vec` matches a reference model that applies the lane's operation per element.
